// File: rtl/easy_fifo_pkg.sv
// Shared helpers for the easy_fifo family: counter/width sizing functions and
// the lane-phase encoding used by the AXI-Stream width adapters.
package easy_fifo_pkg;

   typedef enum logic {
      PH_FILL = 1'b0,
      PH_LAST = 1'b1
   } lane_phase_e;

   // Counter width for n states, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int out_width(input int dwidth, input int ratio);
      return dwidth * ratio;
   endfunction

endpackage

// File: rtl/easy_fifo_axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat, lane 0 first.
// Optional packet support (tlast/tkeep, short final words) under EASY_FIFO_TLAST_EN.
module easy_fifo_axis_upsizer
   import easy_fifo_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int RATIO  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DWIDTH-1:0]          s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
`ifdef EASY_FIFO_TLAST_EN
   input  logic                       s_axis_tlast,
   output logic [RATIO-1:0]           m_axis_tkeep,
   output logic                       m_axis_tlast,
`endif
   output logic [DWIDTH*RATIO-1:0]    m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready
);

   localparam int CW = clog2_min1(RATIO);
   localparam int OW = out_width(DWIDTH, RATIO);
   localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

   logic [CW-1:0]     cnt;
   logic [DWIDTH-1:0] pack_p0 [RATIO-1];
   logic [OW-1:0]     data_p1;
   logic              vld_p1;
   logic [OW-1:0]     word_nxt;
   lane_phase_e       phase;
   logic              out_free;
   logic              complete_beat;
   logic              s_hs;
   logic              m_hs;
`ifdef EASY_FIFO_TLAST_EN
   logic [RATIO-1:0]  keep_nxt;
   logic [RATIO-1:0]  keep_p1;
   logic              last_p1;
`endif

   assign phase    = (cnt == CNT_LAST) ? PH_LAST : PH_FILL;
   assign out_free = ~vld_p1 | m_axis_tready;

   // A beat that completes a word needs the output register free; any other beat
   // only lands in the pack register and can always be taken.
   always_comb begin
      complete_beat = 1'b0;
      s_axis_tready = 1'b1;
`ifdef EASY_FIFO_TLAST_EN
      complete_beat = (phase == PH_LAST) | s_axis_tlast;
      if (phase == PH_LAST)
         s_axis_tready = out_free;
      else
         s_axis_tready = ~s_axis_tvalid | ~s_axis_tlast | out_free;
`else
      complete_beat = (phase == PH_LAST);
      if (phase == PH_LAST)
         s_axis_tready = out_free;
`endif
   end

   assign s_hs = s_axis_tvalid & s_axis_tready;
   assign m_hs = vld_p1 & m_axis_tready;

   // Lanes below cnt come from the pack register, lane cnt is the arriving beat,
   // lanes above cnt stay zero (only reachable on an early tlast).
   always_comb begin
      word_nxt = '0;
      for (int k = 0; k < RATIO - 1; k++) begin
         if (CW'(k) < cnt)
            word_nxt[k*DWIDTH +: DWIDTH] = pack_p0[k];
         else if (CW'(k) == cnt)
            word_nxt[k*DWIDTH +: DWIDTH] = s_axis_tdata;
      end
      if (phase == PH_LAST)
         word_nxt[OW-1 -: DWIDTH] = s_axis_tdata;
   end

`ifdef EASY_FIFO_TLAST_EN
   always_comb begin
      keep_nxt = '0;
      for (int k = 0; k < RATIO; k++)
         keep_nxt[k] = (CW'(k) <= cnt);
   end
`endif

   // pack stage (p0) -> output stage (p1)
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         for (int k = 0; k < RATIO - 1; k++)
            pack_p0[k] <= '0;
`ifdef EASY_FIFO_TLAST_EN
         keep_p1 <= '0;
         last_p1 <= 1'b0;
`endif
      end else begin
         if (s_hs && !complete_beat) begin
            for (int k = 0; k < RATIO - 1; k++)
               if (CW'(k) == cnt)
                  pack_p0[k] <= s_axis_tdata;
            cnt <= cnt + CW'(1);
         end
         // Loading a new word takes priority over draining, so a simultaneous
         // drain and completion keeps valid high with no bubble.
         if (s_hs && complete_beat) begin
            data_p1 <= word_nxt;
            vld_p1  <= 1'b1;
            cnt     <= '0;
`ifdef EASY_FIFO_TLAST_EN
            keep_p1 <= keep_nxt;
            last_p1 <= s_axis_tlast;
`endif
         end else if (m_hs) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign m_axis_tdata  = data_p1;
   assign m_axis_tvalid = vld_p1;
`ifdef EASY_FIFO_TLAST_EN
   assign m_axis_tkeep  = keep_p1;
   assign m_axis_tlast  = last_p1;
`endif

endmodule

// File: tb/tb_easy_fifo_axis_upsizer.sv
// Bench for easy_fifo_axis_upsizer (DWIDTH=8, RATIO=4): queue-based model plus
// directed vectors; packet tests are built when EASY_FIFO_TLAST_EN is defined.
module tb_easy_fifo_axis_upsizer;

   localparam int DW = 8;
   localparam int RT = 4;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        clk;
   logic        rst;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic [3:0]  m_tkeep;
   logic        m_tlast;

   int checks = 0;
   int errors = 0;

   word_t      exp_q[$];
   word_t      log_q[$];
   logic [7:0] beats[$];
   bit         prev_rst = 0;
   int         stall_cnt = 0;
   int         vld_cycles = 0;

   easy_fifo_axis_upsizer #(.DWIDTH(DW), .RATIO(RT)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
`ifdef EASY_FIFO_TLAST_EN
      .s_axis_tlast  (s_tlast),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
`endif
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready)
   );

`ifndef EASY_FIFO_TLAST_EN
   assign m_tkeep = 4'hF;
   assign m_tlast = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: a word is produced once RATIO beats (or a tlast beat) have been
   // accepted; it is visible until the consumer takes it. A beat that would
   // complete a word is refused while the previous word is held and not taken.
   always @(negedge clk) begin
      word_t w;
      bit    completes;
      bit    exp_ready;
      bit    s_hs;
      bit    m_hs;

      completes = (beats.size() == RT - 1);
`ifdef EASY_FIFO_TLAST_EN
      completes = completes || (s_tvalid && s_tlast);
`endif
      exp_ready = !completes || (exp_q.size() == 0) || m_tready;

      chk("m_tvalid", m_tvalid, exp_q.size() > 0);
      chk("s_tready", s_tready, exp_ready);
      if (exp_q.size() > 0) begin
         chk("m_tdata", m_tdata, exp_q[0].data);
`ifdef EASY_FIFO_TLAST_EN
         chk("m_tkeep", m_tkeep, exp_q[0].keep);
         chk("m_tlast", m_tlast, exp_q[0].last);
`endif
      end
      if (prev_rst) begin
         chk("rst_tdata", m_tdata, 0);
`ifdef EASY_FIFO_TLAST_EN
         chk("rst_tkeep", m_tkeep, 0);
         chk("rst_tlast", m_tlast, 0);
`endif
      end

      if (m_tvalid) vld_cycles++;
      if (s_tvalid && !s_tready) stall_cnt++;

      if (rst) begin
         exp_q.delete();
         beats.delete();
         prev_rst = 1;
      end else begin
         prev_rst = 0;
         s_hs = s_tvalid && exp_ready;
         m_hs = (exp_q.size() > 0) && m_tready;
         if (m_hs) begin
            log_q.push_back(exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (s_hs) begin
            beats.push_back(s_tdata);
            if (completes) begin
               w.data = '0;
               for (int i = 0; i < beats.size(); i++)
                  w.data = w.data | (32'(beats[i]) << (8 * i));
               w.keep = 4'((1 << beats.size()) - 1);
`ifdef EASY_FIFO_TLAST_EN
               w.last = s_tlast;
`else
               w.last = 1'b0;
`endif
               exp_q.push_back(w);
               beats.delete();
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic l);
      bit ok;
      int n;
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      ok = 0;
      n  = 0;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: beat %0h not accepted within %0d cycles", d, n);
      end
   endtask

   task automatic idle();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      rst      = 1'b1;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_tvalid", m_tvalid, 0);
      chk("reset_tdata", m_tdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", s_tready, 1);
      @(posedge clk);
      #1;

      // Single word, exact latency and one-cycle valid
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      idle();
      vld_cycles = 0;
      @(negedge clk);
      chk("t1_vld_next_cycle", m_tvalid, 1);
      chk("t1_data", m_tdata, 32'h44332211);
      @(negedge clk);
      chk("t1_vld_dropped", m_tvalid, 0);
      settle(2);
      chk("t1_vld_cycles", vld_cycles, 1);
      chk("t1_log", log_q[0].data, 32'h44332211);

      // Continuous stream 0x00..0x0F
      base = log_q.size();
      stall_cnt = 0;
      for (int i = 0; i < 16; i++) send(8'(i), 0);
      idle();
      settle(3);
      chk("t2_no_stall", stall_cnt, 0);
      chk("t2_count", log_q.size() - base, 4);
      chk("t2_w0", log_q[base].data, 32'h03020100);
      chk("t2_w1", log_q[base+1].data, 32'h07060504);
      chk("t2_w2", log_q[base+2].data, 32'h0B0A0908);
      chk("t2_w3", log_q[base+3].data, 32'h0F0E0D0C);

      // Backpressure: one word held, three beats more, then stall
      base = log_q.size();
      m_tready = 1'b0;
      for (int i = 0; i < 7; i++) send(8'(8'h10 + i), 0);
      s_tdata  = 8'h17;
      s_tvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t3_stalled_ready", s_tready, 0);
         chk("t3_held_vld", m_tvalid, 1);
         chk("t3_held_data", m_tdata, 32'h13121110);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      send(8'h17, 0);
      idle();
      settle(3);
      chk("t3_count", log_q.size() - base, 2);
      chk("t3_w0", log_q[base].data, 32'h13121110);
      chk("t3_w1", log_q[base+1].data, 32'h17161514);

      // Reset discards a partial word
      base = log_q.size();
      send(8'hAA, 0); send(8'hBB, 0);
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t4_rst_data", m_tdata, 0);
      chk("t4_rst_vld", m_tvalid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      idle();
      settle(3);
      chk("t4_count", log_q.size() - base, 1);
      chk("t4_w0", log_q[base].data, 32'h04030201);

`ifdef EASY_FIFO_TLAST_EN
      // Short packet then a full packet starting at lane 0
      base = log_q.size();
      send(8'h11, 0); send(8'h22, 1);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      idle();
      settle(3);
      chk("t5_count", log_q.size() - base, 2);
      chk("t5_w0_data", log_q[base].data, 32'h00002211);
      chk("t5_w0_keep", log_q[base].keep, 4'b0011);
      chk("t5_w0_last", log_q[base].last, 1);
      chk("t5_w1_data", log_q[base+1].data, 32'h04030201);
      chk("t5_w1_keep", log_q[base+1].keep, 4'b1111);
      chk("t5_w1_last", log_q[base+1].last, 0);

      // Single-beat packet while the output is stalled
      base = log_q.size();
      m_tready = 1'b0;
      send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
      s_tdata  = 8'h5A;
      s_tlast  = 1'b1;
      s_tvalid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("t6_stalled_ready", s_tready, 0);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      send(8'h5A, 1);
      idle();
      settle(3);
      chk("t6_count", log_q.size() - base, 2);
      chk("t6_w0_data", log_q[base].data, 32'hA4A3A2A1);
      chk("t6_w1_data", log_q[base+1].data, 32'h0000005A);
      chk("t6_w1_keep", log_q[base+1].keep, 4'b0001);
      chk("t6_w1_last", log_q[base+1].last, 1);
`endif

      chk("model_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
